// File: rtl/hssi_axis_arb_pkg.sv
// Shared types and defaults for the AXI4-Stream to Avalon-ST TX arbiter.
// Holds the arbiter state enum, width defaults and a reference empty helper.
package hssi_axis_arb_pkg;

  localparam int DATA_W_DEF     = 512;
  localparam int NUM_BYTES_DEF  = DATA_W_DEF / 8;
  localparam int EMPTY_BITS_DEF = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Unused byte count of a beat: only eop beats carry a nonzero value,
  // and only the highest set keep bit matters.
  function automatic logic [EMPTY_BITS_DEF-1:0] keep_to_empty(
    input logic [NUM_BYTES_DEF-1:0] keep,
    input logic                     last
  );
    logic [EMPTY_BITS_DEF-1:0] e;
    e = '0;
    if (last) begin
      for (int i = 0; i < NUM_BYTES_DEF; i++) begin
        if (keep[i]) begin
          e = EMPTY_BITS_DEF'(NUM_BYTES_DEF - 1 - i);
        end
      end
    end
    return e;
  endfunction

endpackage

// File: rtl/tkeep_msb_enc.sv
// Highest-set-bit priority encoder for a tkeep vector.
// Ports: keep in; idx = index of highest set bit; any = some bit set.
module tkeep_msb_enc #(
  parameter int N  = 64,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  keep,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    idx = '0;
    any = |keep;
    for (int i = 0; i < N; i++) begin
      if (keep[i]) begin
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/axis2avst_tx_arb.sv
// Packet-level round-robin merge of two AXI4-Stream TX sources onto one
// Avalon-ST MAC TX port. Ports: s0_*/s1_* AXIS sinks, avst_* source,
// pkt_cnt0/1 eop counters per requester, clk with sync active-high rst.
module axis2avst_tx_arb
  import hssi_axis_arb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int EMPTY_BITS = EMPTY_BITS_DEF,
  parameter int USER_W     = 1,
  parameter int NUM_BYTES  = DATA_W / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [DATA_W-1:0]     s0_tdata,
  input  logic [NUM_BYTES-1:0]  s0_tkeep,
  input  logic                  s0_tvalid,
  input  logic                  s0_tlast,
  input  logic [USER_W-1:0]     s0_tuser,
  output logic                  s0_tready,

  input  logic [DATA_W-1:0]     s1_tdata,
  input  logic [NUM_BYTES-1:0]  s1_tkeep,
  input  logic                  s1_tvalid,
  input  logic                  s1_tlast,
  input  logic [USER_W-1:0]     s1_tuser,
  output logic                  s1_tready,

  output logic [DATA_W-1:0]     avst_data,
  output logic                  avst_valid,
  output logic                  avst_sop,
  output logic                  avst_eop,
  output logic [EMPTY_BITS-1:0] avst_empty,
  output logic [USER_W-1:0]     avst_error,
  input  logic                  avst_ready,

  output logic [31:0]           pkt_cnt0,
  output logic [31:0]           pkt_cnt1
);

  localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  arb_state_t state, state_nxt;
  logic       rr, rr_nxt;
  logic       first;

  logic                  load;
  logic                  sel;
  logic                  acc;
  logic                  acc_last;
  logic [DATA_W-1:0]     m_data;
  logic [NUM_BYTES-1:0]  m_keep;
  logic                  m_last;
  logic [USER_W-1:0]     m_user;
  logic [IW-1:0]         msb_idx;
  logic                  msb_any;
  logic [EMPTY_BITS-1:0] empty_c;

  // Output register can take a beat when empty or draining this cycle.
  assign load      = ~avst_valid | avst_ready;
  assign s0_tready = (state == OWN0) & load;
  assign s1_tready = (state == OWN1) & load;

  assign sel    = (state == OWN1);
  assign m_data = sel ? s1_tdata  : s0_tdata;
  assign m_keep = sel ? s1_tkeep  : s0_tkeep;
  assign m_last = sel ? s1_tlast  : s0_tlast;
  assign m_user = sel ? s1_tuser  : s0_tuser;

  assign acc = (s0_tvalid & s0_tready)
             | (s1_tvalid & s1_tready);
  assign acc_last = acc & m_last;

  tkeep_msb_enc #(
    .N  (NUM_BYTES),
    .IW (IW)
  ) u_msb_enc (
    .keep (m_keep),
    .idx  (msb_idx),
    .any  (msb_any)
  );

  always_comb begin
    empty_c = '0;
    if (msb_any) begin
      empty_c = EMPTY_BITS'(NUM_BYTES - 1 - int'(msb_idx));
    end
  end

  // On a tlast acceptance the finishing requester's tvalid belongs to the
  // beat just consumed, so it is not treated as a fresh request; the other
  // side wins if valid, else the grant is released to IDLE.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    unique case (state)
      IDLE: begin
        if (s0_tvalid && s1_tvalid) begin
          state_nxt = rr ? OWN1 : OWN0;
        end else if (s0_tvalid) begin
          state_nxt = OWN0;
        end else if (s1_tvalid) begin
          state_nxt = OWN1;
        end
      end
      OWN0: begin
        if (acc_last) begin
          rr_nxt    = 1'b1;
          state_nxt = s1_tvalid ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (acc_last) begin
          rr_nxt    = 1'b0;
          state_nxt = s0_tvalid ? OWN0 : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr         <= 1'b0;
      first      <= 1'b1;
      avst_valid <= 1'b0;
      avst_sop   <= 1'b0;
      avst_eop   <= 1'b0;
      avst_empty <= '0;
      avst_error <= '0;
      avst_data  <= '0;
      pkt_cnt0   <= '0;
      pkt_cnt1   <= '0;
    end else begin
      state <= state_nxt;
      rr    <= rr_nxt;
      if (acc) begin
        first <= m_last;
      end
      if (load) begin
        avst_valid <= acc;
        if (acc) begin
          avst_data  <= m_data;
          avst_sop   <= first;
          avst_eop   <= m_last;
          avst_empty <= m_last ? empty_c : '0;
          avst_error <= m_last ? m_user : '0;
        end
      end
      if (acc_last && !sel) begin
        pkt_cnt0 <= pkt_cnt0 + 32'd1;
      end
      if (acc_last && sel) begin
        pkt_cnt1 <= pkt_cnt1 + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_axis2avst_tx_arb.sv
// Self-checking bench for axis2avst_tx_arb: per-requester packet queues,
// a packet-level scoreboard and directed plus random scenarios.
module tb_axis2avst_tx_arb;

  localparam int DW = 512;
  localparam int NB = 64;
  localparam int EB = 6;
  localparam int UW = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [DW-1:0] s0_tdata, s1_tdata;
  logic [NB-1:0] s0_tkeep, s1_tkeep;
  logic          s0_tvalid, s1_tvalid;
  logic          s0_tlast, s1_tlast;
  logic [UW-1:0] s0_tuser, s1_tuser;
  logic          s0_tready, s1_tready;
  logic [DW-1:0] avst_data;
  logic          avst_valid, avst_sop, avst_eop;
  logic [EB-1:0] avst_empty;
  logic [UW-1:0] avst_error;
  logic          avst_ready;
  logic [31:0]   pkt_cnt0, pkt_cnt1;

  axis2avst_tx_arb dut (
    .clk        (clk),
    .rst        (rst),
    .s0_tdata   (s0_tdata),
    .s0_tkeep   (s0_tkeep),
    .s0_tvalid  (s0_tvalid),
    .s0_tlast   (s0_tlast),
    .s0_tuser   (s0_tuser),
    .s0_tready  (s0_tready),
    .s1_tdata   (s1_tdata),
    .s1_tkeep   (s1_tkeep),
    .s1_tvalid  (s1_tvalid),
    .s1_tlast   (s1_tlast),
    .s1_tuser   (s1_tuser),
    .s1_tready  (s1_tready),
    .avst_data  (avst_data),
    .avst_valid (avst_valid),
    .avst_sop   (avst_sop),
    .avst_eop   (avst_eop),
    .avst_empty (avst_empty),
    .avst_error (avst_error),
    .avst_ready (avst_ready),
    .pkt_cnt0   (pkt_cnt0),
    .pkt_cnt1   (pkt_cnt1)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [NB-1:0] k;
    logic          l;
    logic [UW-1:0] u;
  } in_t;

  typedef struct {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
    logic [EB-1:0] e;
    logic [UW-1:0] u;
  } ex_t;

  in_t iq0[$], iq1[$];
  ex_t eq0[$], eq1[$];
  int  log_src[$];
  int  log_cyc[$];
  logic [EB-1:0] eop_emp[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int cur = 0;
  int acc0 = 0;
  int acc1 = 0;
  logic [31:0] cnt_exp0, cnt_exp1;

  // Empty from the rule: unused bytes above the highest kept byte.
  function automatic logic [EB-1:0] exp_empty(
    input logic [NB-1:0] k, input logic l);
    if (!l) return '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (k[i]) return EB'(NB - 1 - i);
    end
    return '0;
  endfunction

  task automatic push_pkt(input int s, input int n,
                          input logic [NB-1:0] lkeep,
                          input logic [UW-1:0] u);
    in_t b;
    ex_t e;
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < DW / 32; w++) b.d[w*32 +: 32] = $urandom;
      b.d[DW-1 -: 8] = 8'(s);
      b.l = (i == n - 1);
      b.k = b.l ? lkeep : {$urandom, $urandom};
      b.u = b.l ? u : UW'($urandom);
      e.d   = b.d;
      e.sop = (i == 0);
      e.eop = b.l;
      e.e   = exp_empty(b.k, b.l);
      e.u   = b.l ? b.u : '0;
      if (s == 0) begin
        iq0.push_back(b);
        eq0.push_back(e);
      end else begin
        iq1.push_back(b);
        eq1.push_back(e);
      end
    end
    if (s == 0) cnt_exp0 = cnt_exp0 + 32'd1;
    else cnt_exp1 = cnt_exp1 + 32'd1;
  endtask

  task automatic clear_model();
    iq0.delete();
    iq1.delete();
    eq0.delete();
    eq1.delete();
    log_src.delete();
    log_cyc.delete();
    eop_emp.delete();
    cur = 0;
    cnt_exp0 = '0;
    cnt_exp1 = '0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    avst_ready = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    rst = 1'b0;
    clear_model();
  endtask

  // One clock: present beats, monitor at negedge, retire after posedge.
  task automatic step(input int vpct, input int rpct);
    logic a0, a1;
    int   src;
    ex_t  e;
    logic have;
    if (!s0_tvalid && iq0.size() > 0 && $urandom_range(99) < vpct) begin
      s0_tvalid = 1'b1;
      s0_tdata  = iq0[0].d;
      s0_tkeep  = iq0[0].k;
      s0_tlast  = iq0[0].l;
      s0_tuser  = iq0[0].u;
    end
    if (!s1_tvalid && iq1.size() > 0 && $urandom_range(99) < vpct) begin
      s1_tvalid = 1'b1;
      s1_tdata  = iq1[0].d;
      s1_tkeep  = iq1[0].k;
      s1_tlast  = iq1[0].l;
      s1_tuser  = iq1[0].u;
    end
    avst_ready = ($urandom_range(99) < rpct);
    @(negedge clk);
    a0 = s0_tvalid & s0_tready;
    a1 = s1_tvalid & s1_tready;
    if (avst_valid && !avst_ready) begin
      checks++;
      if (s0_tready !== 1'b0 || s1_tready !== 1'b0) begin
        errors++;
        $display("FAIL stall_tready cyc=%0d got=%b%b want=00",
                 cyc, s0_tready, s1_tready);
      end
    end
    if (avst_valid === 1'b1) begin
      src = avst_sop ? int'(avst_data[DW-1 -: 8]) : cur;
      have = (src == 0) ? (eq0.size() > 0)
           : (src == 1) ? (eq1.size() > 0) : 1'b0;
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL unexpected_beat cyc=%0d src=%0d sop=%b eop=%b",
                 cyc, src, avst_sop, avst_eop);
      end else begin
        e = (src == 0) ? eq0[0] : eq1[0];
        if (avst_data !== e.d || avst_sop !== e.sop ||
            avst_eop !== e.eop || avst_empty !== e.e ||
            avst_error !== e.u) begin
          errors++;
          $display({"FAIL beat cyc=%0d src=%0d got d=%h sop=%b eop=%b",
                    " emp=%0d err=%b want d=%h sop=%b eop=%b emp=%0d err=%b"},
                   cyc, src, avst_data[63:0], avst_sop, avst_eop,
                   avst_empty, avst_error, e.d[63:0], e.sop, e.eop,
                   e.e, e.u);
        end
        if (avst_ready) begin
          if (src == 0) eq0.delete(0);
          else eq1.delete(0);
          cur = src;
          if (avst_sop) begin
            log_src.push_back(src);
            log_cyc.push_back(cyc);
          end
          if (avst_eop) eop_emp.push_back(avst_empty);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (a0) begin
      iq0.delete(0);
      s0_tvalid = 1'b0;
      acc0++;
    end
    if (a1) begin
      iq1.delete(0);
      s1_tvalid = 1'b0;
      acc1++;
    end
  endtask

  task automatic drain(input int vpct, input int rpct, input string nm);
    int n = 0;
    while ((iq0.size() + iq1.size() + eq0.size() + eq1.size()) > 0 &&
           n < 3000) begin
      step(vpct, rpct);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_timeout left=%0d want=0", nm,
               iq0.size() + iq1.size() + eq0.size() + eq1.size());
    end
    repeat (3) step(vpct, 100);
    checks++;
    if (pkt_cnt0 !== cnt_exp0 || pkt_cnt1 !== cnt_exp1) begin
      errors++;
      $display("FAIL %s_counters got=%0d/%0d want=%0d/%0d", nm,
               pkt_cnt0, pkt_cnt1, cnt_exp0, cnt_exp1);
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    checks++;
    if ({avst_valid, avst_sop, avst_eop} !== 3'b000 ||
        avst_empty !== '0 || avst_error !== '0 ||
        avst_data !== '0) begin
      errors++;
      $display("FAIL %s_avst got v=%b s=%b e=%b emp=%0d err=%b want 0",
               nm, avst_valid, avst_sop, avst_eop, avst_empty, avst_error);
    end
    checks++;
    if (s0_tready !== 1'b0 || s1_tready !== 1'b0) begin
      errors++;
      $display("FAIL %s_tready got=%b%b want=00", nm, s0_tready, s1_tready);
    end
    checks++;
    if (pkt_cnt0 !== 32'd0 || pkt_cnt1 !== 32'd0) begin
      errors++;
      $display("FAIL %s_cnt got=%0d/%0d want=0/0", nm, pkt_cnt0, pkt_cnt1);
    end
  endtask

  task automatic test_reset();
    do_reset(3);
    check_idle_outputs("reset");
  endtask

  task automatic test_single();
    do_reset(2);
    push_pkt(0, 3, 64'h0000_0000_0000_00FF, 1'b0);
    drain(100, 100, "single");
    checks++;
    if (eop_emp.size() != 1 || eop_emp[0] !== 6'd56) begin
      errors++;
      $display("FAIL single_empty got=%0d n=%0d want=56",
               (eop_emp.size() > 0) ? eop_emp[0] : 6'd0, eop_emp.size());
    end
    checks++;
    if (pkt_cnt0 !== 32'd1) begin
      errors++;
      $display("FAIL single_cnt0 got=%0d want=1", pkt_cnt0);
    end
  endtask

  task automatic test_contention();
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      push_pkt(0, 1, '1, 1'b0);
      push_pkt(1, 1, '1, 1'b0);
    end
    drain(100, 100, "contention");
    checks++;
    if (log_src.size() != 8) begin
      errors++;
      $display("FAIL contention_pkts got=%0d want=8", log_src.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (log_src[i] != (i % 2) || log_cyc[i] != log_cyc[0] + i) begin
          errors++;
          $display("FAIL contention_order i=%0d got src=%0d cyc=%0d want src=%0d cyc=%0d",
                   i, log_src[i], log_cyc[i], i % 2, log_cyc[0] + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    do_reset(2);
    push_pkt(0, 4, {$urandom, $urandom}, 1'b1);
    while (eq0.size() > 2 && n < 50) begin
      step(100, 100);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL bp_start_timeout left=%0d want=2", eq0.size());
    end
    repeat (5) step(100, 0);
    checks++;
    if (eq0.size() != 2) begin
      errors++;
      $display("FAIL bp_hold beats_left got=%0d want=2", eq0.size());
    end
    drain(100, 100, "backpressure");
  endtask

  task automatic test_keep_edges();
    logic [NB-1:0] kk;
    do_reset(2);
    kk = '0;
    kk[NB-1] = 1'b1;
    kk[0] = 1'b1;
    push_pkt(0, 1, '0, 1'b0);
    push_pkt(0, 1, 64'h1, 1'b1);
    push_pkt(0, 1, kk, 1'b0);
    drain(100, 100, "keep");
    checks++;
    if (eop_emp.size() != 3) begin
      errors++;
      $display("FAIL keep_count got=%0d want=3", eop_emp.size());
    end else begin
      checks++;
      if (eop_emp[0] !== 6'd0 || eop_emp[1] !== 6'd63 ||
          eop_emp[2] !== 6'd0) begin
        errors++;
        $display("FAIL keep_empty got=%0d,%0d,%0d want=0,63,0",
                 eop_emp[0], eop_emp[1], eop_emp[2]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset(2);
    acc1 = 0;
    push_pkt(1, 4, '1, 1'b0);
    while (acc1 < 2 && n < 50) begin
      step(100, 100);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL rstmid_timeout accepted=%0d want=2", acc1);
    end
    s1_tvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    clear_model();
    check_idle_outputs("rstmid");
    push_pkt(1, 2, 64'h00FF, 1'b1);
    push_pkt(0, 2, 64'h0F0F, 1'b0);
    drain(100, 100, "rstmid");
    checks++;
    if (log_src.size() != 2 || log_src[0] != 0) begin
      errors++;
      $display("FAIL rstmid_first_grant got=%0d n=%0d want=0",
               (log_src.size() > 0) ? log_src[0] : -1, log_src.size());
    end
  endtask

  task automatic test_counter_wrap();
    do_reset(2);
    force dut.pkt_cnt1 = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    cyc++;
    release dut.pkt_cnt1;
    cnt_exp1 = 32'hFFFF_FFFF;
    push_pkt(1, 2, '1, 1'b0);
    drain(100, 100, "wrap");
    checks++;
    if (pkt_cnt1 !== 32'd0) begin
      errors++;
      $display("FAIL wrap_cnt1 got=%h want=0", pkt_cnt1);
    end
  endtask

  task automatic test_random();
    do_reset(2);
    for (int i = 0; i < 12; i++) begin
      push_pkt(0, $urandom_range(1, 4), {$urandom, $urandom},
               UW'($urandom));
      push_pkt(1, $urandom_range(1, 4), {$urandom, $urandom},
               UW'($urandom));
    end
    drain(70, 70, "random");
    checks++;
    if (log_src.size() != 24) begin
      errors++;
      $display("FAIL random_pkts got=%0d want=24", log_src.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    s0_tdata = '0;
    s1_tdata = '0;
    s0_tkeep = '0;
    s1_tkeep = '0;
    s0_tlast = 1'b0;
    s1_tlast = 1'b0;
    s0_tuser = '0;
    s1_tuser = '0;
    avst_ready = 1'b0;
    cnt_exp0 = '0;
    cnt_exp1 = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_keep_edges();
    test_reset_mid();
    test_counter_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axis2avst_tx_arb.md
# axis2avst_tx_arb

Two-requester, packet-level round-robin arbiter. It merges two AXI4-Stream TX sources onto one Avalon-ST MAC TX port in the HSSI subsystem. The block owns the single output register stage and converts each beat from keep to Avalon-ST: it generates the sop and eop flags and the empty count, with empty derived from tkeep. Grants are held for a whole packet, so packets are never interleaved on the output.

## Interface
- DATA_W, 512, data width in bits; NUM_BYTES = DATA_W/8.
- EMPTY_BITS, 6, width of avst_empty; must equal log2(NUM_BYTES).
- USER_W, 1, tuser width, passed through to avst_error on the eop beat.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- s0_tdata / s1_tdata  in  DATA_W  requester data.
- s0_tkeep / s1_tkeep  in  NUM_BYTES  byte enables; bit 0 is the first byte.
- s0_tvalid / s1_tvalid  in  1  beat valid.
- s0_tlast / s1_tlast  in  1  last beat of packet.
- s0_tuser / s1_tuser  in  USER_W  error tag.
- s0_tready / s1_tready  out  1  beat accepted when tvalid && tready.
- avst_data  out  DATA_W  output data.
- avst_valid  out  1  output valid.
- avst_sop, avst_eop  out  1  packet delimiters.
- avst_empty  out  EMPTY_BITS  unused bytes on the eop beat.
- avst_error  out  USER_W  tuser of the eop beat, 0 otherwise.
- avst_ready  in  1  sink ready, readyLatency 0.
- pkt_cnt0, pkt_cnt1  out  32  eop beats forwarded per requester; wraps.

## Operation
- States:
  - IDLE: no owner.
  - OWN0: requester 0 holds the grant.
  - OWN1: requester 1 holds the grant.
- Round-robin pointer rr. After reset rr=0, meaning requester 0 has priority.
- IDLE, transitions:
  - Only s0_tvalid set -> OWN0.
  - Only s1_tvalid set -> OWN1.
  - Both set -> the owner is the requester named by rr.
  - Neither set -> stay in IDLE.
- IDLE, output: no tready is asserted while in IDLE.
- OWNn, tready: sn_tready = (~avst_valid | avst_ready). The other requester's tready is 0.
- On acceptance of the sn_tlast beat:
  - rr is set to the other requester.
  - Arbitration is evaluated combinationally in the same cycle using the updated priority, so the next owner is registered for the following cycle with no bubble.
  - If neither requester is valid, go to IDLE.
- sop generation: a first-beat flag is set on reset and after each accepted tlast, and cleared on any other accepted beat. avst_sop equals the flag captured with the beat.
- Empty computation, eop beats:
  - avst_empty = NUM_BYTES-1-(index of the highest set tkeep bit).
  - tkeep all ones -> 0.
  - tkeep all zeros -> 0, and the beat is still forwarded.
  - Non-contiguous keep uses the highest set bit only.
- Empty computation, non-eop beats: avst_empty = 0, whatever tkeep holds.
- Empty width: the computed value is truncated to EMPTY_BITS.
- Counters: pkt_cnt for the owning requester increments when an eop beat is accepted into the output register.
- Reset mid-packet:
  - State goes to IDLE, rr=0, first-beat flag=1.
  - Output register is cleared; the in-flight partial packet is dropped, with no eop emitted.
  - Counters are cleared.

## Timing
- Reset values:
  - avst_valid, avst_sop, avst_eop = 0.
  - avst_empty, avst_error = 0.
  - avst_data = 0.
  - s0_tready, s1_tready = 0.
  - pkt_cnt0, pkt_cnt1 = 0.
- Latency: a beat accepted in cycle N appears on avst_* in cycle N+1.
- Arbitration from IDLE costs one cycle: tvalid is seen in cycle N, the grant is registered in N+1, and the first beat is accepted in N+1 at the earliest.
- Backpressure:
  - The output register holds its contents while avst_valid && !avst_ready.
  - tready depends combinationally on avst_ready and the registered state only, never on tvalid.
- Throughput: one beat per cycle under continuous avst_ready, including back-to-back single-beat packets that alternate requesters.
- Simultaneous events: a tlast acceptance and a new tvalid from the other requester in the same cycle -> the grant moves over, with no idle cycle.

## Structure
- Package hssi_axis_arb_pkg holds:
  - the state enum (IDLE, OWN0, OWN1);
  - the DATA_W/NUM_BYTES/EMPTY_BITS defaults;
  - the function keep_to_empty(keep, last).
- Sub-module tkeep_msb_enc: a parameterized priority encoder. It takes NUM_BYTES in and produces the highest-set index plus an any-set flag, purely combinational. The arbiter instantiates it once, on the muxed tkeep.
- The top level contains the state machine, rr, the data mux, the output register and the counters.

## Test plan
- Single requester: s0 sends 3 beats, with final tkeep = 0x0000_0000_0000_00FF. Required output: sop on beat 1, eop on beat 3, avst_empty=56 on beat 3, pkt_cnt0=1.
- Contention: both requesters are valid continuously with 1-beat packets and full keep, starting just after reset. Required grant order is 0,1,0,1 with no bubble after the first arbitration cycle; every beat has sop=eop=1 and empty=0.
- Backpressure: avst_ready is held low for 5 cycles mid-packet. Required: avst_* stays stable, s0_tready=0 throughout, no beat is lost or duplicated, and beat order is preserved.
- Keep edge cases on eop:
  - tkeep=0 -> empty=0.
  - tkeep=0x1 -> empty=63.
  - tkeep=0x8000_0000_0000_0001 -> empty=0.
- Reset mid-packet: rst is asserted for 1 cycle after beat 2 of 4 from s1. Required: all outputs return to their reset values, the partial packet is dropped, and after reset both requesters are valid and s0 is granted first.
- Counter wrap: pkt_cnt1 is preset via force to 0xFFFF_FFFF, then one packet is sent. Required: pkt_cnt1 = 0.
